alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequencer/arbiter that shares the single 16-bit ALU between two requesters (req0, req1), e.g. the execute stage and a multi-cycle helper unit.
- Accepts op/operand requests on a valid/ready handshake and registers the operands that drive the ALU.
- Captures the ALU result and returns it on a response channel tagged with the requester ID.
- Owns the architectural N/Z/V flag register and applies the per-opcode flag-update rules.

Parameters:
DW, 16, datapath width (operands, result)
OPW, 3, ALU opcode width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an op
req0_ready  output  1  requester 0 op accepted this cycle
req0_op  input  OPW  requester 0 opcode
req0_a  input  DW  requester 0 operand 1
req0_b  input  DW  requester 0 operand 2
req1_valid, req1_ready, req1_op, req1_a, req1_b  (as req0, for requester 1)
alu_op  output  OPW  registered opcode to ALU
alu_in1  output  DW  registered operand 1 to ALU
alu_in2  output  DW  registered operand 2 to ALU
alu_out  input  DW  ALU combinational result
alu_flag  input  3  ALU flags [N Z V], valid for ADD/SUB only
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  requester that issued the op
rsp_data  output  DW  captured result
flags  output  3  architectural flag register [N Z V]

Behaviour:
- Opcodes: 000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB.
- Reset (async, rst_n low):
  - state=IDLE; all outputs 0 (alu_op, alu_in1/2, rsp_*, flags, req*_ready); last_grant=1.
  - An in-flight op is discarded; requesters must resubmit.
- FSM states IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Arbitration:
    - If exactly one reqN_valid, grant N.
    - If both are valid, grant the requester != last_grant (round-robin).
    - First grant after reset goes to req0.
  - reqN_ready=1 combinationally for the granted requester only, in IDLE only; never both high.
  - On the handshake edge: latch op/a/b into alu_op/alu_in1/alu_in2, latch grant into rsp_id and last_grant, go to EXEC.
- EXEC (one cycle): ALU settles.
  - At the edge: rsp_data<=alu_out; rsp_valid<=1; flag update; go to RESP.
- Flag update at the EXEC edge:
  - ADD/SUB: flags<=alu_flag.
  - XOR/SLL/SRA/ROR: only Z changes, Z<=(alu_out==0), computed locally; N and V are held.
  - RED/PADDSB: flags held.
- RESP:
  - rsp_valid held high and rsp_id/rsp_data stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
- Latency and throughput:
  - Accept at edge k -> rsp_valid high after edge k+1.
  - Minimum 3 cycles per op.
  - A new request is never accepted in the cycle the response completes.
- alu_in1/alu_in2/alu_op hold their last value outside EXEC; no glitching.
- Requester-side rules:
  - A requester holding valid with ready low must keep op/a/b stable.
  - Dropping valid before grant is legal; no op is issued.
- Flags update exactly once per op, never on stall cycles in RESP.

Optional Feature:
ALU_FIXED_PRIO_EN
- Defined: fixed priority; req0 always wins when both are valid; last_grant is unused; req1 can starve.
- Undefined (default): round-robin as in Behaviour.

Test Plan:
- Reset then req0 ADD a=0x7FFF b=0x0001, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid two edges later, rsp_id=0, rsp_data=ALU result, flags=alu_flag (model: N=1,Z=0,V=1).
- Both valid continuously, 4 ops each, rsp_ready=1 -> grants alternate 0,1,0,1,...; the first grant is req0; no op is lost or duplicated.
- req1 XOR a=0x00FF b=0x00FF after ADD set flags=3'b101 -> rsp_data=0x0000, flags=3'b111 (only Z changed).
- PADDSB after SUB -> flags unchanged from the SUB result; RED also leaves flags unchanged.
- rsp_ready low 5 cycles in RESP with req0_valid high -> rsp_data/rsp_id stable; req0_ready=0 throughout; flags change once; req0 is accepted the cycle after the response handshake.
- rst_n low during EXEC -> all outputs 0 immediately (async); after release, the first request is served normally and the flags start from 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer sharing one ALU between two requesters, with N/Z/V flag ownership.
// Define ALU_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module alu_issue_ctrl #(
  parameter int DW  = 16,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [OPW-1:0] alu_op,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  input  logic [DW-1:0]  alu_out,
  input  logic [2:0]     alu_flag,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic [2:0]     flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(3);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR = OPW'(6);

  state_t state, state_nxt;
  logic   grant;
  logic   grant_vld;
  logic   accept;

  assign grant_vld = req0_valid | req1_valid;
  assign accept    = (state == IDLE) && grant_vld;

`ifdef ALU_FIXED_PRIO_EN
  // req1 is granted only when req0 is not asking.
  assign grant = ~req0_valid;
`else
  logic last_grant;

  // On contention, the requester that did not win last time goes next.
  assign grant = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;

  // Reset to 1 so the first contended grant goes to req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is combinational; it is forced low while rst_n is asserted so all outputs read 0.
  always_comb begin
    req0_ready = rst_n && accept && !grant;
    req1_ready = rst_n && accept &&  grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op    <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      flags     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op  <= grant ? req1_op : req0_op;
            alu_in1 <= grant ? req1_a  : req0_a;
            alu_in2 <= grant ? req1_b  : req0_b;
            rsp_id  <= grant;
          end
        end
        EXEC: begin
          rsp_data  <= alu_out;
          rsp_valid <= 1'b1;
          case (alu_op)
            OP_ADD, OP_SUB:                 flags    <= alu_flag;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags[1] <= (alu_out == '0);
            default:                        ;
          endcase
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
